// File: rtl/mips_control_sequencer_if.sv
// rtl/mips_control_sequencer_if.sv - instruction fetch request/valid bus
interface mips_control_sequencer_if;
   logic        instrReq;
   logic [31:0] instrAddr;
   logic        instrValid;
   logic [31:0] instrData;

   modport master (
      output instrReq,
      output instrAddr,
      input  instrValid,
      input  instrData
   );

   modport slave (
      input  instrReq,
      input  instrAddr,
      output instrValid,
      output instrData
   );
endinterface

// File: rtl/mips_control_sequencer.sv
// rtl/mips_control_sequencer.sv - multi-cycle fetch/control sequencer for the MIPS datapath
module mips_control_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      run,
   mips_control_sequencer_if.master  imem,
   input  logic                      aluZero,
   output logic [31:0]               pc,
   output logic [31:0]               instruction,
   output logic                      RegDst,
   output logic                      ALUSrc,
   output logic                      MemtoReg,
   output logic                      MemRead,
   output logic                      MemWrite,
   output logic                      RegWrite,
   output logic [3:0]                ALUCtrl,
   output logic                      instrDone,
   output logic                      halted
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] C_R    = 3'd0;
   localparam logic [2:0] C_LW   = 3'd1;
   localparam logic [2:0] C_SW   = 3'd2;
   localparam logic [2:0] C_ADDI = 3'd3;
   localparam logic [2:0] C_BEQ  = 3'd4;
   localparam logic [2:0] C_J    = 3'd5;
   localparam logic [2:0] C_ILL  = 3'd6;

   typedef struct packed {
      logic [2:0] cls;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic [3:0] alu_ctrl;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d     = '0;
      d.cls = C_ILL;
      case (w[31:26])
         6'h00: begin
            d.cls     = C_R;
            d.reg_dst = 1'b1;
            case (w[5:0])
               6'h20:   d.alu_ctrl = 4'b0010;
               6'h22:   d.alu_ctrl = 4'b0110;
               6'h24:   d.alu_ctrl = 4'b0000;
               6'h25:   d.alu_ctrl = 4'b0001;
               6'h2A:   d.alu_ctrl = 4'b0111;
               6'h27:   d.alu_ctrl = 4'b1100;
               default: d.cls      = C_ILL;
            endcase
         end
         6'h23: begin
            d.cls        = C_LW;
            d.alu_ctrl   = 4'b0010;
            d.alu_src    = 1'b1;
            d.mem_to_reg = 1'b1;
         end
         6'h2B: begin
            d.cls      = C_SW;
            d.alu_ctrl = 4'b0010;
            d.alu_src  = 1'b1;
         end
         6'h08: begin
            d.cls      = C_ADDI;
            d.alu_ctrl = 4'b0010;
            d.alu_src  = 1'b1;
         end
         6'h04: begin
            d.cls      = C_BEQ;
            d.alu_ctrl = 4'b0110;
         end
         6'h02:   d.cls = C_J;
         default: d.cls = C_ILL;
      endcase
      return d;
   endfunction

   logic [2:0]  state;
   logic [2:0]  cls;
   dec_t        fetch_dec;
   logic [31:0] br_off;

   assign fetch_dec      = decode(imem.instrData);
   assign br_off         = {{14{instruction[15]}}, instruction[15:0], 2'b00};
   assign imem.instrAddr = pc;

   // Outputs are registered: each is written on the edge that enters the state it belongs to.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         instruction <= '0;
         cls         <= C_ILL;
         RegDst      <= 1'b0;
         ALUSrc      <= 1'b0;
         MemtoReg    <= 1'b0;
         ALUCtrl     <= '0;
         MemRead     <= 1'b0;
         MemWrite    <= 1'b0;
         RegWrite    <= 1'b0;
         imem.instrReq <= 1'b0;
         instrDone   <= 1'b0;
         halted      <= 1'b0;
      end else begin
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         RegWrite  <= 1'b0;
         instrDone <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  state         <= S_FETCH;
                  imem.instrReq <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem.instrValid) begin
                  instruction   <= imem.instrData;
                  pc            <= pc + 32'd4;
                  cls           <= fetch_dec.cls;
                  RegDst        <= fetch_dec.reg_dst;
                  ALUSrc        <= fetch_dec.alu_src;
                  MemtoReg      <= fetch_dec.mem_to_reg;
                  ALUCtrl       <= fetch_dec.alu_ctrl;
                  imem.instrReq <= 1'b0;
                  instrDone     <= (fetch_dec.cls == C_J);
                  state         <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (cls == C_ILL) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else if (cls == C_J) begin
                  pc            <= {pc[31:28], instruction[25:0], 2'b00};
                  state         <= run ? S_FETCH : S_IDLE;
                  imem.instrReq <= run;
               end else begin
                  state     <= S_EXEC;
                  instrDone <= (cls == C_BEQ);
               end
            end
            S_EXEC: begin
               case (cls)
                  C_BEQ: begin
                     if (aluZero) pc <= pc + br_off;
                     state         <= run ? S_FETCH : S_IDLE;
                     imem.instrReq <= run;
                  end
                  C_LW: begin
                     state   <= S_MEM;
                     MemRead <= 1'b1;
                  end
                  C_SW: begin
                     state     <= S_MEM;
                     MemWrite  <= 1'b1;
                     instrDone <= 1'b1;
                  end
                  default: begin
                     state     <= S_WB;
                     RegWrite  <= 1'b1;
                     instrDone <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (cls == C_LW) begin
                  state     <= S_WB;
                  MemRead   <= 1'b1;
                  RegWrite  <= 1'b1;
                  instrDone <= 1'b1;
               end else begin
                  state         <= run ? S_FETCH : S_IDLE;
                  imem.instrReq <= run;
               end
            end
            S_WB: begin
               state         <= run ? S_FETCH : S_IDLE;
               imem.instrReq <= run;
            end
            S_HALT: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
